layer_mem_arbiter: RTL

Two-requester arbiter and sequencer for the shared single-port layer memory (csel/crd/cwr bank interface). It lets the atrous-conv/max-pool engine (requester 0) and a host readback/debug port (requester 1) share the memory. Per cycle it grants at most one access, registers the memory-side strobes, and returns read data with a fixed latency. It sits between the compute engine and the L0/L1 memory banks in the top level.

---
 rtl/lma_pkg.sv | 22 ++
 rtl/lma_rr_picker.sv | 41 ++++
 rtl/layer_mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lma_pkg.sv
// rtl/lma_pkg.sv - shared types and defaults for the layer memory arbiter
package lma_pkg;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 13;
    localparam int DEF_MAX_BURST = 16;

    localparam logic SEL_L0 = 1'b0;
    localparam logic SEL_L1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } lma_state_e;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/lma_rr_picker.sv
// rtl/lma_rr_picker.sv - combinational grant logic; LMA_FIXED_PRIO_EN selects strict r0 priority
module lma_rr_picker
    import lma_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int BURST_W   = 4
) (
`ifndef LMA_FIXED_PRIO_EN
    input  lma_state_e         state_i,
    input  logic [BURST_W-1:0] burst_cnt_i,
`endif
    input  logic [1:0]         req_i,
    output logic [1:0]         gnt_o
);

`ifndef LMA_FIXED_PRIO_EN
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
`endif

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: begin
`ifdef LMA_FIXED_PRIO_EN
                gnt_o = 2'b01;
`else
                // The owner keeps the port until its contended burst is used up.
                case (state_i)
                    OWN0:    gnt_o = (burst_cnt_i < BURST_LAST) ? 2'b01 : 2'b10;
                    OWN1:    gnt_o = (burst_cnt_i < BURST_LAST) ? 2'b10 : 2'b01;
                    default: gnt_o = 2'b01;
                endcase
`endif
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/layer_mem_arbiter.sv
// rtl/layer_mem_arbiter.sv - two-requester arbiter/sequencer for the shared layer memory
// Define LMA_FIXED_PRIO_EN for strict requester-0 priority without burst fairness.
module layer_mem_arbiter
    import lma_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_sel,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_sel,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              cwr,
    output logic              crd,
    output logic              csel,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_wr,
    input  logic [DATA_W-1:0] cdata_rd
);

    localparam int BURST_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

    lma_state_e        state_q, state_d;
    logic [1:0]        req, pick, gnt;
    logic              g_we, g_sel;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    logic              cwr_q, cwr_d, crd_q, crd_d, csel_q, csel_d;
    logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
    logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d;
    rd_tag_t           tag1_q, tag1_d, tag2_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    assign req = {r1_req, r0_req};

`ifdef LMA_FIXED_PRIO_EN
    lma_rr_picker #(.MAX_BURST(MAX_BURST), .BURST_W(BURST_W)) u_picker (
        .req_i (req),
        .gnt_o (pick)
    );
`else
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    logic [BURST_W-1:0] burst_q, burst_d;

    lma_rr_picker #(.MAX_BURST(MAX_BURST), .BURST_W(BURST_W)) u_picker (
        .state_i     (state_q),
        .burst_cnt_i (burst_q),
        .req_i       (req),
        .gnt_o       (pick)
    );

    // Counts only contended re-grants to the current owner.
    always_comb begin
        burst_d = '0;
        if ((gnt[0] && state_q == OWN0 && req[1]) || (gnt[1] && state_q == OWN1 && req[0]))
            burst_d = (burst_q == BURST_LAST) ? burst_q : burst_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) burst_q <= '0;
        else       burst_q <= burst_d;
    end
`endif

    // No grant can be taken while reset is held.
    assign gnt     = pick & {2{~reset}};
    assign r0_gnt  = gnt[0];
    assign r1_gnt  = gnt[1];
    assign g_we    = gnt[1] ? r1_we    : r0_we;
    assign g_sel   = gnt[1] ? r1_sel   : r0_sel;
    assign g_addr  = gnt[1] ? r1_addr  : r0_addr;
    assign g_wdata = gnt[1] ? r1_wdata : r0_wdata;

    always_comb begin
        state_d    = state_q;
        cwr_d      = (|gnt) & g_we;
        crd_d      = (|gnt) & ~g_we;
        csel_d     = csel_q;
        caddr_wr_d = caddr_wr_q;
        caddr_rd_d = caddr_rd_q;
        cdata_wr_d = cdata_wr_q;
        tag1_d     = '{valid: (|gnt) & ~g_we, id: gnt[1]};

        if (gnt[0])         state_d = OWN0;
        else if (gnt[1])    state_d = OWN1;
        else if (req == '0) state_d = IDLE;

        if (|gnt) begin
            csel_d = g_sel;
            if (g_we) begin
                caddr_wr_d = g_addr;
                cdata_wr_d = g_wdata;
            end else begin
                caddr_rd_d = g_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= SEL_L0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            csel_q     <= csel_d;
            caddr_wr_q <= caddr_wr_d;
            caddr_rd_q <= caddr_rd_d;
            cdata_wr_q <= cdata_wr_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
            if (tag2_q.valid && !tag2_q.id) rdata0_q <= cdata_rd;
            if (tag2_q.valid &&  tag2_q.id) rdata1_q <= cdata_rd;
        end
    end

    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign csel     = csel_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;

    // Memory data is forwarded in its return cycle; the register holds it afterwards.
    assign r0_rvalid = tag2_q.valid & ~tag2_q.id;
    assign r1_rvalid = tag2_q.valid &  tag2_q.id;
    assign r0_rdata  = r0_rvalid ? cdata_rd : rdata0_q;
    assign r1_rdata  = r1_rvalid ? cdata_rd : rdata1_q;

endmodule
